// File: rtl/trap_event_logger_if.sv
// rtl/trap_event_logger_if.sv - event capture and byte stream bundle for trap_event_logger
interface trap_event_logger_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
);
  logic               ev_valid;
  logic [CAUSE_W-1:0] ev_cause;
  logic [31:0]        ev_instr;
  logic [XLEN-1:0]    ev_pc;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output ev_valid, ev_cause, ev_instr, ev_pc, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  ev_valid, ev_cause, ev_instr, ev_pc, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/trap_event_logger.sv
// rtl/trap_event_logger.sv - trap/error event FIFO rendered as ASCII lines on a byte stream
module trap_event_logger #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int CAUSE_W = 4,
  parameter int ONESHOT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  trap_event_logger_if.slave     bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt
);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int N        = XLEN / 4;
  localparam int EVT_LEN  = 25 + N;
  localparam int DROP_LEN = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND_EVT,
    S_LOAD_DROP,
    S_SEND_DROP
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  logic [CAUSE_W-1:0] r_mem_cause [DEPTH];
  logic [31:0]        r_mem_instr [DEPTH];
  logic [XLEN-1:0]    r_mem_pc    [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [7:0]         r_line_cause;
  logic [31:0]        r_line_instr;
  logic [XLEN-1:0]    r_line_pc;
  logic [15:0]        r_line_drop;
  logic [5:0]         r_idx;

  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_busy;
  logic [15:0]        r_drop_cnt;
  logic               r_taken;

  logic               w_hs;
  logic               w_last_evt;
  logic               w_last_drop;
  logic               w_pop;
  logic               w_full;
  logic               w_ev_en;
  logic               w_push;
  logic               w_drop;
  logic [CW-1:0]      w_count_nxt;
  int                 w_nidx;
  logic [7:0]         w_byte;

  assign w_hs        = r_tx_valid && bus.tx_ready;
  assign w_last_evt  = (int'(r_idx) == EVT_LEN - 1);
  assign w_last_drop = (int'(r_idx) == DROP_LEN - 1);
  assign w_pop       = (r_state == S_SEND_EVT) && w_hs && w_last_evt;
  assign w_full      = (r_count == CW'(DEPTH));
  // In one-shot mode everything after the first accepted event is ignored, not counted.
  assign w_ev_en     = bus.ev_valid && !((ONESHOT != 0) && r_taken);
  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign w_push      = w_ev_en && (!w_full || w_pop);
  assign w_drop      = w_ev_en && w_full && !w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign busy         = r_busy;
  assign level        = r_count;
  assign drop_cnt     = r_drop_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: an event being pushed while idle starts a line immediately; events beat drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0 || w_push)   w_state_nxt = S_LOAD;
        else if (r_drop_cnt != 16'h0)  w_state_nxt = S_LOAD_DROP;
      end
      S_LOAD:      w_state_nxt = S_SEND_EVT;
      S_SEND_EVT:  if (w_pop) w_state_nxt = S_IDLE;
      S_LOAD_DROP: w_state_nxt = S_SEND_DROP;
      S_SEND_DROP: if (w_hs && w_last_drop) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Render the byte that follows the one currently on the stream.
  always_comb begin
    w_nidx = int'(r_idx) + 1;
    w_byte = 8'h00;
    if (r_state == S_SEND_DROP) begin
      if      (w_nidx == 0) w_byte = "D";
      else if (w_nidx == 1) w_byte = "=";
      else if (w_nidx == 2) w_byte = "0";
      else if (w_nidx == 3) w_byte = "x";
      else if (w_nidx <= 7) w_byte = hex_ascii(4'(r_line_drop >> (4 * (7 - w_nidx))));
      else if (w_nidx == 8) w_byte = 8'h0D;
      else                  w_byte = 8'h0A;
    end else begin
      if      (w_nidx == 0)      w_byte = "E";
      else if (w_nidx == 1)      w_byte = "=";
      else if (w_nidx <= 3)      w_byte = hex_ascii(4'(r_line_cause >> (4 * (3 - w_nidx))));
      else if (w_nidx == 4)      w_byte = " ";
      else if (w_nidx == 5)      w_byte = "I";
      else if (w_nidx == 6)      w_byte = "=";
      else if (w_nidx == 7)      w_byte = "0";
      else if (w_nidx == 8)      w_byte = "x";
      else if (w_nidx <= 16)     w_byte = hex_ascii(4'(r_line_instr >> (4 * (16 - w_nidx))));
      else if (w_nidx == 17)     w_byte = " ";
      else if (w_nidx == 18)     w_byte = "P";
      else if (w_nidx == 19)     w_byte = "C";
      else if (w_nidx == 20)     w_byte = "=";
      else if (w_nidx == 21)     w_byte = "0";
      else if (w_nidx == 22)     w_byte = "x";
      else if (w_nidx <= 22 + N) w_byte = hex_ascii(4'(r_line_pc >> (4 * (22 + N - w_nidx))));
      else if (w_nidx == 23 + N) w_byte = 8'h0D;
      else                       w_byte = 8'h0A;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cause[r_wr_ptr] <= bus.ev_cause;
      r_mem_instr[r_wr_ptr] <= bus.ev_instr;
      r_mem_pc[r_wr_ptr]    <= bus.ev_pc;
    end
  end

  // FIFO bookkeeping, drop accounting, line register and byte stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_taken      <= 1'b0;
      r_drop_cnt   <= 16'h0;
      r_busy       <= 1'b0;
      r_line_cause <= 8'h0;
      r_line_instr <= 32'h0;
      r_line_pc    <= '0;
      r_line_drop  <= 16'h0;
      r_idx        <= 6'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_push) r_taken <= 1'b1;

      // Snapshot-and-clear wins over a simultaneous drop, which then restarts the count at 1.
      if (r_state == S_LOAD_DROP)
        r_drop_cnt <= w_drop ? 16'h1 : 16'h0;
      else if (w_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;

      r_busy <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);

      case (r_state)
        S_LOAD: begin
          r_line_cause <= 8'(r_mem_cause[r_rd_ptr]);
          r_line_instr <= r_mem_instr[r_rd_ptr];
          r_line_pc    <= r_mem_pc[r_rd_ptr];
          r_idx        <= 6'd0;
          r_tx_valid   <= 1'b1;
          r_tx_data    <= "E";
        end
        S_LOAD_DROP: begin
          r_line_drop <= r_drop_cnt;
          r_idx       <= 6'd0;
          r_tx_valid  <= 1'b1;
          r_tx_data   <= "D";
        end
        S_SEND_EVT, S_SEND_DROP: begin
          if (w_hs) begin
            if ((r_state == S_SEND_EVT && w_last_evt) || (r_state == S_SEND_DROP && w_last_drop)) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
            end else begin
              r_idx     <= r_idx + 6'd1;
              r_tx_data <= w_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_event_logger.sv
// tb/tb_trap_event_logger.sv - self-checking bench for trap_event_logger
module tb_trap_event_logger;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_event_logger_if #(.XLEN(32), .CAUSE_W(4)) if0 ();
  trap_event_logger_if #(.XLEN(64), .CAUSE_W(4)) if1 ();

  logic        busy0, busy1;
  logic [2:0]  level0, level1;
  logic [15:0] drop0, drop1;

  trap_event_logger #(.XLEN(32), .DEPTH(4), .CAUSE_W(4), .ONESHOT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .busy(busy0), .level(level0), .drop_cnt(drop0)
  );
  trap_event_logger #(.XLEN(64), .DEPTH(4), .CAUSE_W(4), .ONESHOT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .level(level1), .drop_cnt(drop1)
  );

  typedef struct {
    logic [3:0]  cause;
    logic [31:0] instr;
    logic [31:0] pc;
    int          mode;
    string       exp;
  } vec_t;

  vec_t  vecs [4];
  int    total = 0;
  int    bad   = 0;
  string crlf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    int diff;
    total++;
    if (act != exp) begin
      bad++;
      diff = -1;
      for (int i = 0; i < act.len() && i < exp.len(); i++)
        if (diff < 0 && act[i] != exp[i]) diff = i;
      $display("FAIL %s: got %0d bytes required %0d bytes, first difference at byte %0d",
               name, act.len(), exp.len(), diff);
    end
  endtask

  function automatic string hexs(input logic [63:0] v, input int nd);
    string digits = "0123456789ABCDEF";
    string s = "";
    for (int k = nd - 1; k >= 0; k--) s = $sformatf("%s%c", s, digits[int'(v[4*k +: 4])]);
    return s;
  endfunction

  function automatic string ev_line(input logic [3:0] c, input logic [31:0] i,
                                    input logic [63:0] p, input int pc_digits);
    return {"E=", hexs({60'h0, c}, 2), " I=0x", hexs({32'h0, i}, 8), " PC=0x", hexs(p, pc_digits), crlf};
  endfunction

  task automatic set_vec(input int k, input logic [3:0] c, input logic [31:0] i,
                         input logic [31:0] p, input int m, input string e);
    vecs[k].cause = c; vecs[k].instr = i; vecs[k].pc = p; vecs[k].mode = m; vecs[k].exp = e;
  endtask

  task automatic set_ready(input logic r);
    if0.tx_ready = r;
    if1.tx_ready = r;
  endtask

  task automatic push_ev(input int sel, input logic [3:0] c, input logic [31:0] ins, input logic [63:0] pc);
    if (sel == 0) begin
      if0.ev_cause = c; if0.ev_instr = ins; if0.ev_pc = pc[31:0]; if0.ev_valid = 1'b1;
    end else begin
      if1.ev_cause = c; if1.ev_instr = ins; if1.ev_pc = pc; if1.ev_valid = 1'b1;
    end
    @(posedge clk); #1;
    if0.ev_valid = 1'b0;
    if1.ev_valid = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: 20-cycle stall first, then random ready with more long stalls
  task automatic collect(input int sel, input int nbytes, input int mode, input int budget,
                         output string got, output int cycles, output int first_v);
    int         stall_left;
    int         r;
    logic       rdy;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       v;
    logic [7:0] d;
    got = ""; cycles = 0; first_v = -1;
    stall_left = (mode == 1) ? 20 : 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    while (got.len() < nbytes && cycles < budget) begin
      if (mode == 0) rdy = 1'b1;
      else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else begin
        r = $urandom_range(0, 9);
        if (r == 0) begin stall_left = 19; rdy = 1'b0; end
        else rdy = (r > 3);
      end
      set_ready(rdy);
      @(negedge clk);
      v = (sel != 0) ? if1.tx_valid : if0.tx_valid;
      d = (sel != 0) ? if1.tx_data  : if0.tx_data;
      if (prev_stall) chk("stall_hold", {55'h0, v, d}, {55'h0, 1'b1, prev_data});
      if (v && first_v < 0) first_v = cycles;
      if (v && rdy) got = $sformatf("%s%c", got, d);
      prev_stall = v && !rdy;
      prev_data  = d;
      cycles++;
      @(posedge clk); #1;
    end
    chk("collect_len", got.len(), nbytes);
  endtask

  initial begin
    string got, got1, exp;
    int    cyc, fv, n, extra;
    logic [3:0]  rc;
    logic [31:0] ri, rp;

    crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
    set_vec(0, 4'h3, 32'h000000FF, 32'h80000010, 0, "E=03 I=0x000000FF PC=0x80000010");
    set_vec(1, 4'h3, 32'h000000FF, 32'h80000010, 1, "E=03 I=0x000000FF PC=0x80000010");
    set_vec(2, 4'hF, 32'hDEADBEEF, 32'h00000000, 1, "E=0F I=0xDEADBEEF PC=0x00000000");
    set_vec(3, 4'h0, 32'h12345678, 32'hFFFFFFFC, 0, "E=00 I=0x12345678 PC=0xFFFFFFFC");

    rst = 1'b0;
    if0.ev_valid = 1'b0; if0.ev_cause = '0; if0.ev_instr = '0; if0.ev_pc = '0;
    if1.ev_valid = 1'b0; if1.ev_cause = '0; if1.ev_instr = '0; if1.ev_pc = '0;
    set_ready(1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_tx_valid", if0.tx_valid, 0);
    chk("rst_tx_data", if0.tx_data, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_level", level0, 0);
    chk("rst_drop", drop0, 0);
    chk("rst_tx_valid64", if1.tx_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // table-driven single events, with and without backpressure
    for (int v = 0; v < 4; v++) begin
      push_ev(0, vecs[v].cause, vecs[v].instr, {32'h0, vecs[v].pc});
      @(negedge clk);
      chk("lat_c1_level", level0, 1);
      chk("lat_c1_busy", busy0, 1);
      chk("lat_c1_valid", if0.tx_valid, 0);
      @(posedge clk); #1;
      collect(0, 33, vecs[v].mode, 3000, got, cyc, fv);
      chk("lat_c2_first_valid", fv, 0);
      chks($sformatf("line_vec%0d", v), got, {vecs[v].exp, crlf});
      if (vecs[v].mode == 0) chk("line_cycles", cyc, 33);
      @(negedge clk);
      chk("after_busy", busy0, 0);
      chk("after_level", level0, 0);
      chk("after_valid", if0.tx_valid, 0);
      @(posedge clk); #1;
    end

    // overflow: 6 events into a 4-deep FIFO with the sink stalled
    set_ready(1'b0);
    exp = "";
    for (int k = 0; k < 6; k++) begin
      push_ev(0, 4'(k), 32'hA0000000 + k, 64'h1000 + 4 * k);
      if (k < 4) exp = {exp, ev_line(4'(k), 32'hA0000000 + k, 64'h1000 + 4 * k, 8)};
    end
    exp = {exp, "D=0x0002", crlf};
    @(negedge clk);
    chk("ovf_level", level0, 4);
    chk("ovf_drop", drop0, 2);
    @(posedge clk); #1;
    collect(0, 142, 0, 2000, got, cyc, fv);
    chks("ovf_lines", got, exp);
    chk("ovf_gap_cycles", cyc, 150);
    @(negedge clk);
    chk("ovf_drop_cleared", drop0, 0);
    chk("ovf_level_end", level0, 0);
    chk("ovf_busy_end", busy0, 0);
    @(posedge clk); #1;

    // push against a full FIFO in the cycle of the last-byte handshake
    set_ready(1'b0);
    exp = "";
    for (int k = 0; k < 4; k++) begin
      push_ev(0, 4'(k + 8), 32'hC0DE0000 + k, 64'h2000 + 8 * k);
      exp = {exp, ev_line(4'(k + 8), 32'hC0DE0000 + k, 64'h2000 + 8 * k, 8)};
    end
    collect(0, 32, 0, 100, got1, cyc, fv);
    chks("coll_head_prefix", got1, exp.substr(0, 31));
    set_ready(1'b1);
    if0.ev_cause = 4'h7; if0.ev_instr = 32'h77777777; if0.ev_pc = 32'h00007770; if0.ev_valid = 1'b1;
    @(negedge clk);
    chk("coll_full_before", level0, 4);
    chk("coll_last_byte", {if0.tx_valid, if0.tx_data}, {1'b1, 8'h0A});
    @(posedge clk); #1;
    if0.ev_valid = 1'b0;
    @(negedge clk);
    chk("coll_level", level0, 4);
    chk("coll_drop", drop0, 0);
    @(posedge clk); #1;
    collect(0, 132, 0, 1000, got, cyc, fv);
    chks("coll_lines", got, {exp.substr(33, 131), ev_line(4'h7, 32'h77777777, 64'h7770, 8)});
    @(negedge clk);
    chk("coll_drop_end", drop0, 0);
    chk("coll_busy_end", busy0, 0);
    @(posedge clk); #1;

    // randomized bursts against a queue-level model: first DEPTH lines survive, rest are counted
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      set_ready(1'b0);
      exp = "";
      for (int k = 0; k < n; k++) begin
        rc = 4'($urandom_range(0, 15));
        ri = $urandom;
        rp = $urandom;
        push_ev(0, rc, ri, {32'h0, rp});
        if (k < 4) exp = {exp, ev_line(rc, ri, {32'h0, rp}, 8)};
      end
      if (n > 4) exp = {exp, "D=0x", hexs(64'(n - 4), 4), crlf};
      collect(0, exp.len(), 1, 20000, got, cyc, fv);
      chks($sformatf("rand_round%0d_n%0d", r, n), got, exp);
      @(negedge clk);
      chk("rand_drop_end", drop0, 0);
      chk("rand_level_end", level0, 0);
      @(posedge clk); #1;
    end

    // one-shot, 64-bit PC
    set_ready(1'b0);
    push_ev(1, 4'hA, 32'hCAFEF00D, 64'h12345678ABCDEF00);
    push_ev(1, 4'h1, 32'h11111111, 64'h1);
    push_ev(1, 4'h2, 32'h22222222, 64'h2);
    @(negedge clk);
    chk("os_level", level1, 1);
    chk("os_drop", drop1, 0);
    @(posedge clk); #1;
    collect(1, 41, 0, 500, got, cyc, fv);
    chks("os_line", got, {"E=0A I=0xCAFEF00D PC=0x12345678ABCDEF00", crlf});
    extra = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (if1.tx_valid) extra++;
      @(posedge clk); #1;
    end
    chk("os_no_more_lines", extra, 0);
    @(negedge clk);
    chk("os_busy_end", busy1, 0);
    chk("os_drop_end", drop1, 0);
    @(posedge clk); #1;

    // reset asserted mid-line, then a fresh complete line
    push_ev(0, 4'h5, 32'h11223344, 64'h55667788);
    collect(0, 10, 0, 100, got, cyc, fv);
    chks("mid_prefix", got, "E=05 I=0x1");
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", if0.tx_valid, 0);
    chk("mid_rst_data", if0.tx_data, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_level", level0, 0);
    chk("mid_rst_drop", drop0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push_ev(0, 4'h6, 32'h0BADF00D, 64'h00C0FFEE);
    collect(0, 33, 0, 200, got, cyc, fv);
    chk("post_rst_first_valid", fv, 1);
    chks("post_rst_line", got, {"E=06 I=0x0BADF00D PC=0x00C0FFEE", crlf});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
